// File: rtl/composite_pkg.sv
// Shared definitions for the composite sync decoder.
// Holds the pulse-class and vertical-state enums, the default timing
// constants matching the PAL composite sync generator, counter widths
// and the width-to-class helper.
package composite_pkg;

  typedef enum logic [1:0] {
    PULSE_SHORT = 2'd0,
    PULSE_LINE  = 2'd1,
    PULSE_LONG  = 2'd2
  } pulse_class_t;

  typedef enum logic [1:0] {
    LINES   = 2'd0,
    BROAD   = 2'd1,
    POST_EQ = 2'd2
  } vstate_t;

  localparam int unsigned SHORT_MAX_DEF = 41;
  localparam int unsigned LINE_MAX_DEF  = 199;
  localparam int unsigned HALF_LINE_DEF = 383;
  localparam int unsigned TOL_DEF       = 8;
  localparam int unsigned ACTIVE_X_DEF  = 122;

  localparam int unsigned WIDTH_W  = 9;
  localparam int unsigned PERIOD_W = 11;
  localparam int unsigned POS_W    = 10;

  // Period count at which horizontal timing is considered lost.
  localparam int unsigned TIMEOUT_CNT = 1024;

  // Width classification; a saturated width is always wider than any line sync.
  function automatic pulse_class_t classify(input logic [WIDTH_W-1:0] w,
                                            input int unsigned short_max,
                                            input int unsigned line_max);
    if (w <= WIDTH_W'(short_max))     return PULSE_SHORT;
    else if (w <= WIDTH_W'(line_max)) return PULSE_LINE;
    else                              return PULSE_LONG;
  endfunction

endpackage

// File: rtl/sync_pulse_classifier.sv
// Front end of the decoder: synchronizes sync_/vin, detects sync edges,
// measures pulse width and edge-to-edge period, and classifies pulses.
// Ports:
//   clk10, rst_n   clock and async active-low reset
//   sync_, vin     raw asynchronous inputs
//   fall           one-cycle strobe, registered sync falling edge
//   pulse_valid    one-cycle strobe, a pulse just ended; pulse_class valid
//   pulse_class    class of the pulse that just ended
//   prev_period    fall-to-fall period latched at the most recent fall
//   timeout        one-cycle strobe when the period count reaches TIMEOUT_CNT
//   sync_high      synchronized sync level
//   vin_sync       synchronized video level
module sync_pulse_classifier
  import composite_pkg::*;
#(
  parameter int unsigned SHORT_MAX = SHORT_MAX_DEF,
  parameter int unsigned LINE_MAX  = LINE_MAX_DEF
) (
  input  logic                clk10,
  input  logic                rst_n,
  input  logic                sync_,
  input  logic                vin,
  output logic                fall,
  output logic                pulse_valid,
  output pulse_class_t        pulse_class,
  output logic [PERIOD_W-1:0] prev_period,
  output logic                timeout,
  output logic                sync_high,
  output logic                vin_sync
);

  logic                sync_meta;
  logic                sync_prev;
  logic                vin_meta;
  logic [WIDTH_W-1:0]  width;
  logic [PERIOD_W-1:0] period;
  logic                fall_c;
  logic                rise_c;

  assign fall_c = sync_prev & ~sync_high;
  assign rise_c = ~sync_prev & sync_high;

  // Sync flops idle high so reset release does not look like a rising edge.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_high <= 1'b1;
      sync_prev <= 1'b1;
      vin_meta  <= 1'b0;
      vin_sync  <= 1'b0;
    end else begin
      sync_meta <= sync_;
      sync_high <= sync_meta;
      sync_prev <= sync_high;
      vin_meta  <= vin;
      vin_sync  <= vin_meta;
    end
  end

  // Width counts every synchronized low cycle, including the edge cycle.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      width <= '0;
    end else if (fall_c) begin
      width <= WIDTH_W'(1);
    end else if (!sync_high && width != '1) begin
      width <= width + 1'b1;
    end
  end

  // Fall-to-fall period, latched and restarted on each falling edge.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      period      <= '0;
      prev_period <= '0;
    end else if (fall_c) begin
      prev_period <= period;
      period      <= PERIOD_W'(1);
    end else if (period != '1) begin
      period <= period + 1'b1;
    end
  end

  // Registered strobes; timeout cannot coincide with a falling edge.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      fall        <= 1'b0;
      pulse_valid <= 1'b0;
      pulse_class <= PULSE_SHORT;
      timeout     <= 1'b0;
    end else begin
      fall        <= fall_c;
      pulse_valid <= rise_c;
      timeout     <= ~fall_c & (period == PERIOD_W'(TIMEOUT_CNT - 1));
      if (rise_c) begin
        pulse_class <= classify(width, SHORT_MAX, LINE_MAX);
      end
    end
  end

endmodule

// File: rtl/composite_sync_decoder.sv
// Decodes PAL composite sync into horizontal/vertical timing, field parity,
// line number and horizontal position, and gates the video stream.
// Ports:
//   clk10, rst_n   sample clock and async active-low reset
//   sync_, vin     asynchronous composite sync (active low) and video
//   hsync, vsync   one-cycle strobes for line sync and end of broad pulses
//   field          field parity from the gap after the last equalizer
//   line           line count since vsync, saturating
//   xpos           cycles since last sync fall, saturating
//   pix            video gated by lock and the active window
//   locked         horizontal timing valid
module composite_sync_decoder
  import composite_pkg::*;
#(
  parameter int unsigned SHORT_MAX = SHORT_MAX_DEF,
  parameter int unsigned LINE_MAX  = LINE_MAX_DEF,
  parameter int unsigned HALF_LINE = HALF_LINE_DEF,
  parameter int unsigned TOL       = TOL_DEF,
  parameter int unsigned ACTIVE_X  = ACTIVE_X_DEF
) (
  input  logic             clk10,
  input  logic             rst_n,
  input  logic             sync_,
  input  logic             vin,
  output logic             hsync,
  output logic             vsync,
  output logic             field,
  output logic [POS_W-1:0] line,
  output logic [POS_W-1:0] xpos,
  output logic             pix,
  output logic             locked
);

  localparam int unsigned FIRST_ACTIVE_LINE = 22;

  logic                fall;
  logic                pulse_valid;
  pulse_class_t        pulse_class;
  logic [PERIOD_W-1:0] prev_period;
  logic                timeout;
  logic                sync_high;
  logic                vin_sync;

  vstate_t             state;
  vstate_t             state_d;
  logic                hsync_d;
  logic                vsync_d;
  logic                field_d;
  logic [POS_W-1:0]    line_d;
  logic [POS_W-1:0]    line_inc;
  logic [1:0]          good_cnt;
  pulse_class_t        prev_class;
  logic                period_good;

  sync_pulse_classifier #(
    .SHORT_MAX (SHORT_MAX),
    .LINE_MAX  (LINE_MAX)
  ) u_classifier (
    .clk10       (clk10),
    .rst_n       (rst_n),
    .sync_       (sync_),
    .vin         (vin),
    .fall        (fall),
    .pulse_valid (pulse_valid),
    .pulse_class (pulse_class),
    .prev_period (prev_period),
    .timeout     (timeout),
    .sync_high   (sync_high),
    .vin_sync    (vin_sync)
  );

  assign line_inc    = (line == '1) ? line : line + 1'b1;
  assign period_good = (prev_period >= PERIOD_W'(2 * HALF_LINE - TOL)) &&
                       (prev_period <= PERIOD_W'(2 * HALF_LINE + TOL));

  // Vertical FSM state and its registered strobes/counters.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      state <= LINES;
      hsync <= 1'b0;
      vsync <= 1'b0;
      field <= 1'b0;
      line  <= '0;
    end else begin
      state <= state_d;
      hsync <= hsync_d;
      vsync <= vsync_d;
      field <= field_d;
      line  <= line_d;
    end
  end

  // Next state: one class per strobe, so hsync and vsync are exclusive.
  always_comb begin
    state_d = state;
    hsync_d = 1'b0;
    vsync_d = 1'b0;
    field_d = field;
    line_d  = line;
    if (pulse_valid) begin
      case (pulse_class)
        PULSE_SHORT: begin
          if (state == BROAD) begin
            state_d = POST_EQ;
            vsync_d = 1'b1;
            line_d  = '0;
          end
        end
        PULSE_LINE: begin
          hsync_d = 1'b1;
          if (state == LINES) begin
            line_d = line_inc;
          end else if (state == POST_EQ) begin
            state_d = LINES;
            line_d  = line_inc;
            // A one-half-line gap after the last equalizer marks field 0.
            field_d = (prev_period > PERIOD_W'(HALF_LINE + TOL));
          end
        end
        PULSE_LONG: begin
          if (state == LINES) begin
            state_d = BROAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Lock: four consecutive good line-to-line periods; lost on a missing edge.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt   <= '0;
      prev_class <= PULSE_SHORT;
      locked     <= 1'b0;
    end else begin
      if (pulse_valid) begin
        prev_class <= pulse_class;
        if (pulse_class == PULSE_LINE) begin
          if (period_good && prev_class == PULSE_LINE) begin
            if (good_cnt == 2'd3) begin
              locked <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end
      end
      if (timeout && !fall) begin
        locked <= 1'b0;
      end
    end
  end

  // Horizontal position and gated pixel output.
  always_ff @(posedge clk10 or negedge rst_n) begin
    if (!rst_n) begin
      xpos <= '0;
      pix  <= 1'b0;
    end else begin
      if (fall) begin
        xpos <= '0;
      end else if (xpos != '1) begin
        xpos <= xpos + 1'b1;
      end
      pix <= vin_sync & locked & (state == LINES) &
             (line >= POS_W'(FIRST_ACTIVE_LINE)) &
             (xpos >= POS_W'(ACTIVE_X)) & sync_high;
    end
  end

endmodule

// File: tb/tb_composite_sync_decoder.sv
// Self-checking bench for composite_sync_decoder: strobe scoreboard plus a
// table of vertical-interval pulses and hand sequences for lock, timeout
// and mid-line reset.
module tb_composite_sync_decoder;

  logic       clk10;
  logic       rst_n;
  logic       sync_;
  logic       vin;
  logic       hsync;
  logic       vsync;
  logic       field;
  logic [9:0] line;
  logic [9:0] xpos;
  logic       pix;
  logic       locked;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic is_v;
    int   eline;
    logic chk_f;
    logic efield;
  } ev_t;

  typedef struct {
    int   low;
    int   per;
    int   ev;      // 0 none, 1 hsync, 2 vsync
    int   eline;
    logic chk_f;
    logic efield;
  } vec_t;

  ev_t  sb[$];
  vec_t vt[$];

  logic [9:0] last_x = '0;
  logic [9:0] peak   = '0;

  composite_sync_decoder dut (
    .clk10  (clk10),
    .rst_n  (rst_n),
    .sync_  (sync_),
    .vin    (vin),
    .hsync  (hsync),
    .vsync  (vsync),
    .field  (field),
    .line   (line),
    .xpos   (xpos),
    .pix    (pix),
    .locked (locked)
  );

  initial clk10 = 1'b0;
  always #5 clk10 = ~clk10;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic is_v, input int eline, input logic chk_f,
                         input logic efield);
    ev_t e;
    e.is_v = is_v; e.eline = eline; e.chk_f = chk_f; e.efield = efield;
    sb.push_back(e);
  endtask

  task automatic add(input int low, input int per, input int ev, input int eline,
                     input logic chk_f, input logic efield);
    vec_t v;
    v.low = low; v.per = per; v.ev = ev; v.eline = eline;
    v.chk_f = chk_f; v.efield = efield;
    vt.push_back(v);
  endtask

  task automatic pulse(input int low, input int per);
    sync_ = 1'b0;
    repeat (low) @(negedge clk10);
    sync_ = 1'b1;
    repeat (per - low) @(negedge clk10);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk10);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing_strobes: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hsync"},  hsync,  0);
    check({tag, "_vsync"},  vsync,  0);
    check({tag, "_field"},  field,  0);
    check({tag, "_line"},   line,   0);
    check({tag, "_xpos"},   xpos,   0);
    check({tag, "_pix"},    pix,    0);
    check({tag, "_locked"}, locked, 0);
  endtask

  // Scoreboard: every strobe must match the next expected event.
  always @(negedge clk10) begin
    if (hsync && vsync) check("strobe_overlap", 1, 0);
    if (hsync || vsync) begin
      if (sb.size() == 0) begin
        check(vsync ? "unexpected_vsync" : "unexpected_hsync", 1, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("strobe_kind_vsync", vsync, e.is_v);
        check("strobe_line", line, e.eline);
        if (e.chk_f) check("strobe_field", field, e.efield);
      end
    end
  end

  // Last xpos value before each clear.
  always @(negedge clk10) begin
    if (xpos == 10'd0 && last_x != 10'd0) peak <= last_x;
    last_x <= xpos;
  end

  initial begin
    logic pix_seen;
    sync_ = 1'b1;
    vin   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk10);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (50) @(negedge clk10);

    // Line train: lock on the 5th pulse, xpos peaks at period-1.
    for (int i = 0; i < 10; i++) begin
      push_ev(1'b0, i + 1, 1'b1, 1'b0);
      pulse(57, 766);
      check("locked_ramp", locked, (i >= 4) ? 1 : 0);
      if (i >= 1) check("xpos_peak", peak, 765);
    end
    drain("line_train");

    // Timeout: sync held high after a final good line.
    vin = 1'b1;
    push_ev(1'b0, 11, 1'b0, 1'b0);
    sync_ = 1'b0;
    repeat (57) @(negedge clk10);
    sync_ = 1'b1;
    repeat (963) @(negedge clk10);
    check("locked_before_timeout", locked, 1);
    repeat (10) @(negedge clk10);
    check("locked_after_timeout", locked, 0);
    pix_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk10);
      pix_seen = pix_seen | pix;
    end
    check("pix_after_timeout", pix_seen, 0);
    repeat (10) @(negedge clk10);
    drain("timeout");

    // Boundary widths, then field-A and field-B vertical intervals.
    add(41, 766, 0, 0, 1'b0, 1'b0);
    add(42, 766, 1, 12, 1'b0, 1'b0);
    add(199, 766, 1, 13, 1'b0, 1'b0);
    add(200, 766, 0, 0, 1'b0, 1'b0);
    add(27, 383, 2, 0, 1'b0, 1'b0);
    add(199, 766, 1, 1, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 5; k++) add(330, 383, 0, 0, 1'b0, 1'b0);
      add(27, 383, 2, 0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) add(27, 383, 0, 0, 1'b0, 1'b0);
      add(27, (f == 0) ? 383 : 766, 0, 0, 1'b0, 1'b0);
      add(57, 766, 1, 1, 1'b1, 1'(f));
      add(57, 766, 1, 2, 1'b1, 1'(f));
    end
    foreach (vt[n]) begin
      if (vt[n].ev != 0) push_ev(vt[n].ev == 2, vt[n].eline, vt[n].chk_f, vt[n].efield);
      pulse(vt[n].low, vt[n].per);
    end
    drain("vertical_table");

    // Mid-line asynchronous reset with video high.
    push_ev(1'b0, 3, 1'b1, 1'b1);
    sync_ = 1'b0;
    repeat (57) @(negedge clk10);
    sync_ = 1'b1;
    repeat (200) @(negedge clk10);
    check("field_before_reset", field, 1);
    #3 rst_n = 1'b0;
    #1 check_zero("midline_reset");
    @(negedge clk10);
    repeat (2) @(negedge clk10);
    rst_n = 1'b1;
    repeat (300) @(negedge clk10);

    // Relock and active-window gating.
    for (int j = 0; j < 25; j++) begin
      push_ev(1'b0, j + 1, 1'b1, 1'b0);
      sync_ = 1'b0;
      repeat (57) @(negedge clk10);
      sync_ = 1'b1;
      repeat (69) @(negedge clk10);
      if (j == 21) check("pix_xpos_121", pix, 0);
      @(negedge clk10);
      if (j == 21) check("pix_xpos_122", pix, 1);
      repeat (173) @(negedge clk10);
      if (j == 20) check("pix_line_21", pix, 0);
      if (j == 22) check("pix_line_23", pix, 1);
      repeat (466) @(negedge clk10);
      check("relock_ramp", locked, (j >= 4) ? 1 : 0);
    end
    drain("relock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
